// File: rtl/par2ser_stream.sv
// par2ser_stream: valid/ready parallel-to-serial shifter with a one-word holding buffer
module par2ser_stream #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              valid_out,
  output logic              last_out,
  output logic              empty_out
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CMAX = CW'(DATA_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d, hold_q, hold_d;
  logic [CW-1:0]     cnt_q, cnt_d, sel;
  logic              hold_vld_q, hold_vld_d, live_q;
  logic              acc, last;
  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready   = live_q && !hold_vld_q && !flush;
  assign acc        = in_valid && in_ready;
  assign valid_out  = state_q == SHIFT;
  assign last       = valid_out && cnt_q == CMAX;
  assign last_out   = last;
  assign empty_out  = state_q == IDLE && !hold_vld_q;
  assign sel        = MSB_FIRST ? CMAX - cnt_q : cnt_q;
  assign serial_out = valid_out && sreg_q[sel];
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    hold_vld_d = hold_vld_q;
    if (flush) begin
      state_d    = IDLE;
      sreg_d     = '0;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (acc) begin
        sreg_d  = in_data;
        state_d = SHIFT;
        cnt_d   = '0;
      end
    end else if (last) begin
      cnt_d = '0;
      if (hold_vld_q) begin
        sreg_d     = hold_q;
        hold_vld_d = 1'b0;
      end else if (acc) sreg_d = in_data;
      else state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (acc) begin
        hold_d     = in_data;
        hold_vld_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      live_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_par2ser_stream.sv
// tb_par2ser_stream: bit-queue model checks dut_a every cycle; literal sequences pin both instances
module tb_par2ser_stream;
  logic clk = 0, rst_n;
  logic flush_a, in_valid_a, in_ready_a, serial_out_a, valid_out_a, last_out_a, empty_out_a;
  logic [3:0] in_data_a;
  logic flush_b, in_valid_b, in_ready_b, serial_out_b, valid_out_b, last_out_b, empty_out_b;
  logic [7:0] in_data_b;
  int n_run = 0, n_fail = 0, cyc = 0;
  bit got_a[$], lst_a[$], got_b[$], lst_b[$], mq[$];
  int cyc_a[$];
  logic [3:0] sent[$];
  bit started;

  par2ser_stream #(.DATA_W(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .serial_out(serial_out_a), .valid_out(valid_out_a),
    .last_out(last_out_a), .empty_out(empty_out_a));
  par2ser_stream #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .serial_out(serial_out_b), .valid_out(valid_out_b),
    .last_out(last_out_b), .empty_out(empty_out_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // seq lists the expected bits left to right, i.e. seq[n-1] comes first
  task automatic chk_seq(input string nm, input bit q[$], input int n, input logic [15:0] seq);
    chk({nm, "_len"}, q.size(), n);
    if (q.size() == n)
      for (int i = 0; i < n; i++) chk(nm, q[i], seq[n-1-i]);
  endtask

  // Model: a queue of bits still owed on the serial line, one consumed per valid cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      started = 0;
    end else begin
      bit acc;
      acc = in_valid_a && started && !flush_a && mq.size() <= 4;
      if (flush_a) mq.delete();
      else begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (acc) for (int i = 0; i < 4; i++) mq.push_back(in_data_a[i]);
      end
      started = 1;
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = mq.size() > 0;
    chk("m_valid", valid_out_a, ev);
    chk("m_serial", serial_out_a, ev ? mq[0] : 1'b0);
    chk("m_last", last_out_a, ev && (mq.size() % 4 == 1));
    chk("m_empty", empty_out_a, !ev);
    chk("m_ready", in_ready_a, started && !flush_a && mq.size() <= 4);
    if (valid_out_a) begin
      got_a.push_back(serial_out_a);
      lst_a.push_back(last_out_a);
      cyc_a.push_back(cyc);
    end
    if (valid_out_b) begin
      got_b.push_back(serial_out_b);
      lst_b.push_back(last_out_b);
    end
  end

  task automatic clr();
    got_a.delete(); lst_a.delete(); cyc_a.delete(); got_b.delete(); lst_b.delete();
  endtask

  task automatic send_a(input logic [3:0] w);
    int t = 0;
    in_valid_a = 1; in_data_a = w;
    while (!in_ready_a && t < 50) begin @(posedge clk); #1; t++; end
    chk("send_a_ready", in_ready_a, 1);
    sent.push_back(w);
    @(posedge clk); #1;
    in_valid_a = 0;
  endtask

  task automatic send_b(input logic [7:0] w);
    int t = 0;
    in_valid_b = 1; in_data_b = w;
    while (!in_ready_b && t < 50) begin @(posedge clk); #1; t++; end
    chk("send_b_ready", in_ready_b, 1);
    @(posedge clk); #1;
    in_valid_b = 0;
  endtask

  initial begin
    rst_n = 0; flush_a = 0; flush_b = 0; in_valid_a = 0; in_data_a = 0; in_valid_b = 0; in_data_b = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", valid_out_a, 0);
    chk("rst_empty", empty_out_a, 1);
    chk("rst_ready", in_ready_a, 0);
    chk("rst_serial", serial_out_a, 0);
    chk("rst_last", last_out_a, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready_a, 1);
    // single word
    clr();
    send_a(4'h4);
    repeat (6) @(posedge clk); #1;
    chk_seq("t1_bits", got_a, 4, 16'b0010);
    chk_seq("t1_last", lst_a, 4, 16'b0001);
    chk("t1_empty", empty_out_a, 1);
    // back-to-back through the holding buffer
    clr();
    send_a(4'h5);
    send_a(4'hA);
    chk("t2_hold_ready", in_ready_a, 0);
    repeat (10) @(posedge clk); #1;
    chk_seq("t2_bits", got_a, 8, 16'b10100101);
    chk_seq("t2_last", lst_a, 8, 16'b00010001);
    if (cyc_a.size() == 8) chk("t2_contig", cyc_a[7] - cyc_a[0], 7);
    // MSB-first, 8-bit instance
    clr();
    send_b(8'hC3);
    repeat (12) @(posedge clk); #1;
    chk_seq("t3_bits", got_b, 8, 16'b11000011);
    chk_seq("t3_last", lst_b, 8, 16'b00000001);
    chk("t3_empty", empty_out_b, 1);
    // async reset mid-word
    clr();
    send_a(4'h6);
    begin
      int t = 0;
      while (got_a.size() < 2 && t < 20) begin @(negedge clk); #1; t++; end
    end
    chk("t4_two_bits", got_a.size(), 2);
    #1 rst_n = 0;
    #1;
    chk("t4_valid", valid_out_a, 0);
    chk("t4_empty", empty_out_a, 1);
    chk("t4_ready", in_ready_a, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    clr();
    send_a(4'h9);
    repeat (6) @(posedge clk); #1;
    chk_seq("t4_bits", got_a, 4, 16'b1001);
    // flush with shifter busy and hold full
    send_a(4'h3);
    send_a(4'hC);
    in_data_a = 4'h7; in_valid_a = 1; flush_a = 1;
    #1 chk("t5_ready_flush", in_ready_a, 0);
    @(posedge clk); #1;
    chk("t5_valid", valid_out_a, 0);
    chk("t5_empty", empty_out_a, 1);
    flush_a = 0; in_valid_a = 0;
    #1 chk("t5_ready_after", in_ready_a, 1);
    clr();
    repeat (8) @(posedge clk); #1;
    chk("t5_no_output", got_a.size(), 0);
    // random stream
    clr();
    sent.delete();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 send_a(4'($urandom_range(0, 15)));
    end
    repeat (12) @(posedge clk); #1;
    chk("t6_bitcount", got_a.size(), 4 * sent.size());
    if (got_a.size() == 4 * sent.size())
      foreach (sent[k]) begin
        logic [3:0] w;
        for (int i = 0; i < 4; i++) w[i] = got_a[4*k+i];
        chk("t6_word", w, sent[k]);
      end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
